// File: rtl/pipeline_controller_if.sv
// ============================================================================
// pipeline_controller_if : control/hazard bundle between pipeline and controller
// Revision 1.0
// ============================================================================
`default_nettype none

interface pipeline_controller_if #(
   parameter int CNT_W = 32
);
   logic             i_start;
   logic             i_mode;
   logic             i_step;
   logic [5:0]       i_id_opcode;
   logic [4:0]       i_id_rs;
   logic [4:0]       i_id_rt;
   logic             i_ex_MemRead;
   logic [4:0]       i_ex_rt;
   logic             i_ex_branch_taken;
   logic             o_pipe_enable;
   logic             o_pc_write;
   logic             o_ifid_write;
   logic             o_ifid_flush;
   logic             o_control_mux;
   logic             o_running;
   logic             o_halted;
   logic [CNT_W-1:0] o_cycle_count;

   modport slave (
      input  i_start, i_mode, i_step, i_id_opcode, i_id_rs, i_id_rt,
             i_ex_MemRead, i_ex_rt, i_ex_branch_taken,
      output o_pipe_enable, o_pc_write, o_ifid_write, o_ifid_flush,
             o_control_mux, o_running, o_halted, o_cycle_count
   );

   modport master (
      output i_start, i_mode, i_step, i_id_opcode, i_id_rs, i_id_rt,
             i_ex_MemRead, i_ex_rt, i_ex_branch_taken,
      input  o_pipe_enable, o_pc_write, o_ifid_write, o_ifid_flush,
             o_control_mux, o_running, o_halted, o_cycle_count
   );
endinterface

`default_nettype wire

// File: rtl/pipeline_controller.sv
// ============================================================================
// pipeline_controller : run/step/drain sequencing plus load-use/branch hazards
// Revision 1.0
// ============================================================================
`default_nettype none

module pipeline_controller #(
   parameter logic [5:0] HALT_OPCODE  = 6'b111111,
   parameter int         DRAIN_CYCLES = 3,
   parameter int         CNT_W        = 32
) (
   input  wire logic               i_clk,
   input  wire logic               i_rst,
   pipeline_controller_if.slave    bus
);
   localparam int                 c_DRAIN_W    = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [c_DRAIN_W-1:0] c_DRAIN_LOAD = c_DRAIN_W'(DRAIN_CYCLES);
   localparam logic [c_DRAIN_W-1:0] c_DRAIN_ONE  = c_DRAIN_W'(1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RUN       = 3'd1,
      S_STEP_WAIT = 3'd2,
      S_STEP_EXEC = 3'd3,
      S_DRAIN     = 3'd4,
      S_HALTED    = 3'd5
   } state_t;

   state_t                 r_state;
   state_t                 w_next_state;
   logic                   r_step_q;
   logic [c_DRAIN_W-1:0]   r_drain_cnt;
   logic [CNT_W-1:0]       r_cycle_count;

   logic w_step_rise;
   logic w_active;
   logic w_stall;
   logic w_branch;
   logic w_halt_det;

   assign w_step_rise = bus.i_step & ~r_step_q;
   assign w_active    = (r_state == S_RUN) || (r_state == S_STEP_EXEC);
   assign w_stall     = bus.i_ex_MemRead && (bus.i_ex_rt != 5'd0) &&
                        ((bus.i_ex_rt == bus.i_id_rs) || (bus.i_ex_rt == bus.i_id_rt));
   assign w_branch    = bus.i_ex_branch_taken;
   // Halt is only honoured on a clean cycle; a stalled or flushed halt comes back later.
   assign w_halt_det  = w_active && !w_stall && !w_branch && (bus.i_id_opcode == HALT_OPCODE);

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state       <= S_IDLE;
         r_step_q      <= 1'b0;
         r_drain_cnt   <= '0;
         r_cycle_count <= '0;
      end else begin
         r_state  <= w_next_state;
         r_step_q <= bus.i_step;
         if (r_state == S_DRAIN) begin
            r_drain_cnt <= r_drain_cnt - c_DRAIN_ONE;
         end else if (w_halt_det) begin
            r_drain_cnt <= c_DRAIN_LOAD;
         end
         if (bus.o_pipe_enable) begin
            r_cycle_count <= r_cycle_count + 1'b1;
         end
      end
   end

   always_comb begin
      w_next_state      = r_state;
      bus.o_pipe_enable = 1'b0;
      bus.o_pc_write    = 1'b0;
      bus.o_ifid_write  = 1'b0;
      bus.o_ifid_flush  = 1'b0;
      bus.o_control_mux = 1'b0;
      bus.o_running     = 1'b0;
      bus.o_halted      = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (bus.i_start) begin
               w_next_state = bus.i_mode ? S_STEP_WAIT : S_RUN;
            end
         end
         S_RUN, S_STEP_EXEC: begin
            bus.o_pipe_enable = 1'b1;
            bus.o_running     = 1'b1;
            if (r_state == S_STEP_EXEC) begin
               w_next_state = S_STEP_WAIT;
            end
            if (w_branch) begin
               bus.o_pc_write    = 1'b1;
               bus.o_ifid_write  = 1'b1;
               bus.o_ifid_flush  = 1'b1;
            end else if (w_stall) begin
               bus.o_pc_write    = 1'b0;
            end else if (w_halt_det) begin
               bus.o_ifid_write  = 1'b1;
               bus.o_ifid_flush  = 1'b1;
               w_next_state      = S_DRAIN;
            end else begin
               bus.o_pc_write    = 1'b1;
               bus.o_ifid_write  = 1'b1;
               bus.o_control_mux = 1'b1;
            end
         end
         S_STEP_WAIT: begin
            bus.o_running = 1'b1;
            if (w_step_rise) begin
               w_next_state = S_STEP_EXEC;
            end
         end
         S_DRAIN: begin
            bus.o_pipe_enable = 1'b1;
            bus.o_running     = 1'b1;
            if (r_drain_cnt <= c_DRAIN_ONE) begin
               w_next_state = S_HALTED;
            end
         end
         S_HALTED: begin
            bus.o_halted = 1'b1;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   assign bus.o_cycle_count = r_cycle_count;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_controller.sv
// ============================================================================
// tb_pipeline_controller : directed vector table plus randomized model checking
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_controller;
   localparam int         CNT_W = 32;
   localparam logic [5:0] HALT  = 6'b111111;
   localparam int         DRAIN = 3;

   logic i_clk = 1'b0;
   logic i_rst = 1'b0;
   always #5 i_clk = ~i_clk;

   pipeline_controller_if #(.CNT_W(CNT_W)) bus ();

   pipeline_controller #(
      .HALT_OPCODE  (HALT),
      .DRAIN_CYCLES (DRAIN),
      .CNT_W        (CNT_W)
   ) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   typedef struct packed {
      logic       rst, start, mode, step;
      logic [5:0] opc;
      logic [4:0] rs, rt;
      logic       mr;
      logic [4:0] exrt;
      logic       br;
   } in_t;

   // Output vector order: {pipe_enable, pc_write, ifid_write, ifid_flush, control_mux, running, halted}
   typedef struct {
      in_t        in;
      logic [6:0] exp;
      logic [6:0] msk;
      logic [31:0] cnt;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model: the machine is described by what has happened so far
   bit          m_started, m_step_mode, m_exec, m_halted, m_prev_step;
   int          m_drain;
   logic [31:0] m_count;

   function automatic in_t mk(logic rst, logic start, logic mode, logic step, logic [5:0] opc,
                              logic [4:0] rs, logic [4:0] rt, logic mr, logic [4:0] exrt, logic br);
      in_t v;
      v.rst = rst; v.start = start; v.mode = mode; v.step = step; v.opc = opc;
      v.rs = rs; v.rt = rt; v.mr = mr; v.exrt = exrt; v.br = br;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp,
                      input logic [63:0] msk);
      n_checks++;
      if ((act & msk) !== (exp & msk)) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (mask %h)", name, act, exp, msk);
      end
   endtask

   task automatic model_reset();
      m_started = 0; m_step_mode = 0; m_exec = 0; m_halted = 0; m_prev_step = 0;
      m_drain = 0; m_count = '0;
   endtask

   task automatic cycle(input in_t v, input string tag, input bit do_chk,
                        output logic [6:0] act, output logic [31:0] acnt);
      bit draining, active, stall, hdet, waiting, nexec;
      logic [6:0] e, m;
      logic pc, ifw, fl, cm;
      @(negedge i_clk);
      i_rst                 = v.rst;
      bus.i_start           = v.start;
      bus.i_mode            = v.mode;
      bus.i_step            = v.step;
      bus.i_id_opcode       = v.opc;
      bus.i_id_rs           = v.rs;
      bus.i_id_rt           = v.rt;
      bus.i_ex_MemRead      = v.mr;
      bus.i_ex_rt           = v.exrt;
      bus.i_ex_branch_taken = v.br;
      #1;
      draining = (m_drain > 0);
      active   = m_started && !m_halted && !draining && (!m_step_mode || m_exec);
      stall    = v.mr && (v.exrt != 0) && ((v.exrt == v.rs) || (v.exrt == v.rt));
      hdet     = active && !stall && !v.br && (v.opc == HALT);
      m        = 7'b1111111;
      {pc, ifw, fl, cm} = 4'b0000;
      if (active) begin
         if (v.br)            {pc, ifw, fl, cm} = 4'b1110;
         else if (stall)      {pc, ifw, fl, cm} = 4'b0000;
         else if (hdet) begin {pc, ifw, fl, cm} = 4'b0010; m[4] = 1'b0; end
         else                 {pc, ifw, fl, cm} = 4'b1101;
      end
      e = {active || draining, pc, ifw, fl, cm, m_started && !m_halted, m_halted};
      act  = {bus.o_pipe_enable, bus.o_pc_write, bus.o_ifid_write, bus.o_ifid_flush,
              bus.o_control_mux, bus.o_running, bus.o_halted};
      acnt = bus.o_cycle_count;
      if (do_chk) begin
         chk({tag, " model outputs"}, 64'(act), 64'(e), 64'(m));
         chk({tag, " model count"}, 64'(acnt), 64'(m_count), '1);
      end
      @(posedge i_clk);
      if (!v.rst) begin
         model_reset();
      end else begin
         m_count = m_count + 32'(active || draining);
         waiting = m_started && m_step_mode && !m_exec && !draining && !m_halted;
         nexec   = waiting && v.step && !m_prev_step;
         if (!m_started) begin
            if (v.start) begin m_started = 1; m_step_mode = v.mode; end
         end else if (draining) begin
            m_drain--;
            if (m_drain == 0) m_halted = 1;
         end else if (hdet) begin
            m_drain = DRAIN;
         end
         m_exec      = nexec;
         m_prev_step = v.step;
      end
   endtask

   localparam logic [6:0] O_IDLE = 7'b0000000, O_RUN = 7'b1110110, O_STALL = 7'b1000010,
                          O_BR = 7'b1111010, O_HDET = 7'b1001010, O_DRAIN = 7'b1000010,
                          O_HALT = 7'b0000001, O_WAIT = 7'b0000010;
   localparam logic [6:0] M_ALL = 7'b1111111, M_HDET = 7'b1101111;

   initial begin
      vec_t        tbl[26];
      logic [6:0]  act;
      logic [31:0] acnt;
      in_t         v;

      tbl[0]  = '{mk(0,0,0,0,6'h00,5'd1,5'd2,0,5'd0,0), O_IDLE,  M_ALL, 0};
      tbl[1]  = '{mk(1,1,0,0,6'h00,5'd1,5'd2,0,5'd0,0), O_IDLE,  M_ALL, 0};
      tbl[2]  = '{mk(1,0,0,0,6'h00,5'd1,5'd2,0,5'd0,0), O_RUN,   M_ALL, 0};
      tbl[3]  = '{mk(1,0,0,0,6'h00,5'd5,5'd2,1,5'd5,0), O_STALL, M_ALL, 1};
      tbl[4]  = '{mk(1,0,0,0,6'h00,5'd5,5'd2,1,5'd0,0), O_RUN,   M_ALL, 2};
      tbl[5]  = '{mk(1,0,0,0,6'h00,5'd5,5'd2,1,5'd5,1), O_BR,    M_ALL, 3};
      tbl[6]  = '{mk(1,0,0,0,HALT ,5'd1,5'd7,1,5'd7,0), O_STALL, M_ALL, 4};
      tbl[7]  = '{mk(1,0,0,0,HALT ,5'd1,5'd2,0,5'd0,1), O_BR,    M_ALL, 5};
      tbl[8]  = '{mk(1,0,0,0,HALT ,5'd1,5'd2,0,5'd0,0), O_HDET,  M_HDET, 6};
      tbl[9]  = '{mk(1,1,1,1,6'h00,5'd1,5'd2,0,5'd0,0), O_DRAIN, M_ALL, 7};
      tbl[10] = '{mk(1,0,0,0,6'h00,5'd5,5'd2,1,5'd5,1), O_DRAIN, M_ALL, 8};
      tbl[11] = '{mk(1,0,0,0,6'h00,5'd1,5'd2,0,5'd0,0), O_DRAIN, M_ALL, 9};
      tbl[12] = '{mk(1,1,0,0,6'h00,5'd1,5'd2,0,5'd0,0), O_HALT,  M_ALL, 10};
      tbl[13] = '{mk(1,1,1,1,6'h00,5'd1,5'd2,0,5'd0,0), O_HALT,  M_ALL, 10};
      tbl[14] = '{mk(0,0,0,0,6'h00,5'd1,5'd2,0,5'd0,0), O_HALT,  M_ALL, 10};
      tbl[15] = '{mk(1,1,1,0,6'h00,5'd1,5'd2,0,5'd0,0), O_IDLE,  M_ALL, 0};
      tbl[16] = '{mk(1,0,0,0,6'h00,5'd1,5'd2,0,5'd0,0), O_WAIT,  M_ALL, 0};
      tbl[17] = '{mk(1,0,0,1,6'h00,5'd1,5'd2,0,5'd0,0), O_WAIT,  M_ALL, 0};
      tbl[18] = '{mk(1,0,0,1,6'h00,5'd1,5'd2,0,5'd0,0), O_RUN,   M_ALL, 0};
      tbl[19] = '{mk(1,0,0,1,6'h00,5'd1,5'd2,0,5'd0,0), O_WAIT,  M_ALL, 1};
      tbl[20] = '{mk(1,0,0,1,6'h00,5'd1,5'd2,0,5'd0,0), O_WAIT,  M_ALL, 1};
      tbl[21] = '{mk(1,0,0,1,6'h00,5'd1,5'd2,0,5'd0,0), O_WAIT,  M_ALL, 1};
      tbl[22] = '{mk(1,0,0,0,6'h00,5'd1,5'd2,0,5'd0,0), O_WAIT,  M_ALL, 1};
      tbl[23] = '{mk(1,0,0,1,6'h00,5'd1,5'd2,0,5'd0,0), O_WAIT,  M_ALL, 1};
      tbl[24] = '{mk(1,0,0,0,6'h00,5'd1,5'd2,0,5'd0,0), O_RUN,   M_ALL, 1};
      tbl[25] = '{mk(1,0,0,0,6'h00,5'd1,5'd2,0,5'd0,0), O_WAIT,  M_ALL, 2};

      model_reset();
      cycle(mk(0,0,0,0,6'h00,5'd1,5'd2,0,5'd0,0), "prelude", 0, act, acnt);
      cycle(mk(0,0,0,0,6'h00,5'd1,5'd2,0,5'd0,0), "prelude", 0, act, acnt);

      for (int i = 0; i < 26; i++) begin
         cycle(tbl[i].in, $sformatf("vec%0d", i), 1, act, acnt);
         chk($sformatf("vec%0d outputs", i), 64'(act), 64'(tbl[i].exp), 64'(tbl[i].msk));
         chk($sformatf("vec%0d count", i), 64'(acnt), 64'(tbl[i].cnt), '1);
      end

      // Ten clean RUN cycles, then halt, one drain cycle, and reset while draining
      cycle(mk(0,0,0,0,6'h00,5'd1,5'd2,0,5'd0,0), "run10 rst", 1, act, acnt);
      cycle(mk(1,1,0,0,6'h00,5'd1,5'd2,0,5'd0,0), "run10 start", 1, act, acnt);
      for (int i = 0; i < 10; i++) begin
         cycle(mk(1,0,0,0,6'h00,5'd1,5'd2,0,5'd0,0), "run10", 1, act, acnt);
         chk($sformatf("run10 c%0d enable/mux", i), 64'({act[6], act[2]}), 64'(2'b11), '1);
      end
      cycle(mk(1,0,0,0,HALT,5'd1,5'd2,0,5'd0,0), "run10 halt", 1, act, acnt);
      chk("run10 count after 10", 64'(acnt), 64'd10, '1);
      cycle(mk(1,0,0,0,6'h00,5'd1,5'd2,0,5'd0,0), "drain1", 1, act, acnt);
      chk("drain1 outputs", 64'(act), 64'(O_DRAIN), '1);
      cycle(mk(0,0,0,0,6'h00,5'd1,5'd2,0,5'd0,0), "drain rst", 1, act, acnt);
      cycle(mk(1,0,0,0,6'h00,5'd1,5'd2,0,5'd0,0), "after rst", 1, act, acnt);
      chk("abort outputs", 64'(act), 64'(O_IDLE), '1);
      chk("abort count", 64'(acnt), 64'd0, '1);

      // Randomized episodes against the model
      for (int ep = 0; ep < 25; ep++) begin
         cycle(mk(0,0,0,0,6'h00,5'd0,5'd0,0,5'd0,0), "rand rst", 1, act, acnt);
         for (int c = 0; c < 80; c++) begin
            v.rst   = ($urandom_range(0, 99) != 0);
            v.start = ($urandom_range(0, 3) == 0);
            v.mode  = 1'($urandom_range(0, 1));
            v.step  = 1'($urandom_range(0, 1));
            v.opc   = ($urandom_range(0, 9) == 0) ? HALT : 6'($urandom_range(0, 62));
            v.rs    = 5'($urandom_range(0, 3));
            v.rt    = 5'($urandom_range(0, 3));
            v.mr    = 1'($urandom_range(0, 1));
            v.exrt  = 5'($urandom_range(0, 3));
            v.br    = ($urandom_range(0, 5) == 0);
            cycle(v, $sformatf("rand ep%0d c%0d", ep, c), 1, act, acnt);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have parameter HALT_OPCODE, default 6'b111111, the ID-stage opcode that ends execution.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, the enabled cycles after halt detect needed to retire EX/MEM/WB.
REQ-003 SHALL have parameter CNT_W, default 32, the cycle counter width.
REQ-004 SHALL have ports:
  i_clk  in  1  single clock, all state on rising edge
  i_rst  in  1  synchronous, active-low reset
  i_start  in  1  level; launches execution from IDLE
  i_mode  in  1  sampled with i_start; 0 = continuous, 1 = single-step
  i_step  in  1  step request; rising edge detected internally
  i_id_opcode  in  6  opcode in ID stage
  i_id_rs  in  5  rs field in ID
  i_id_rt  in  5  rt field in ID
  i_ex_MemRead  in  1  EX-stage instruction is a load
  i_ex_rt  in  5  load destination register in EX
  i_ex_branch_taken  in  1  branch resolved taken in EX
  o_pipe_enable  out  1  write enable for all pipeline stage registers
  o_pc_write  out  1  PC update enable
  o_ifid_write  out  1  IF/ID register write enable
  o_ifid_flush  out  1  clear IF/ID to NOP
  o_control_mux  out  1  to Control i_control_mux; 0 = zero all control signals (bubble)
  o_running  out  1  state is RUN, STEP_WAIT, STEP_EXEC or DRAIN
  o_halted  out  1  state is HALTED
  o_cycle_count  out  CNT_W  number of cycles with o_pipe_enable = 1

Function
REQ-005 SHALL implement states IDLE, RUN, STEP_WAIT, STEP_EXEC, DRAIN, HALTED; state register and counters registered; hazard outputs combinational from state and inputs.
REQ-006 IDLE: all outputs 0; i_start=1 -> RUN if i_mode=0, STEP_WAIT if i_mode=1.
REQ-007 RUN: o_pipe_enable=1 every cycle.
REQ-008 STEP_WAIT: o_pipe_enable=0, o_pc_write=0, o_ifid_write=0; i_step 0->1 transition (previous-cycle sample 0, current 1) -> STEP_EXEC.
REQ-009 STEP_EXEC: exactly one cycle with o_pipe_enable=1, then STEP_WAIT; held-high i_step SHALL NOT produce a second step.
REQ-010 "Active" = RUN or STEP_EXEC; outside active/DRAIN, o_pc_write, o_ifid_write, o_ifid_flush, o_control_mux SHALL be 0.
REQ-011 Active, no event: o_pc_write=1, o_ifid_write=1, o_control_mux=1, o_ifid_flush=0.
REQ-012 Load-use stall when i_ex_MemRead=1, i_ex_rt!=0, and i_ex_rt equals i_id_rs or i_id_rt: o_pc_write=0, o_ifid_write=0, o_control_mux=0, o_ifid_flush=0.
REQ-013 Branch flush when i_ex_branch_taken=1: o_ifid_flush=1, o_control_mux=0, o_pc_write=1, o_ifid_write=1; branch SHALL take priority over simultaneous stall.
REQ-014 Halt detect when active, i_id_opcode==HALT_OPCODE, no stall, no branch: o_pc_write=0, o_ifid_flush=1, o_control_mux=0; next state DRAIN, drain counter loaded with DRAIN_CYCLES.
REQ-015 Halt opcode coincident with stall or branch SHALL be ignored that cycle (re-evaluated next active cycle).
REQ-016 DRAIN: o_pipe_enable=1, o_pc_write=0, o_ifid_write=0, o_control_mux=0, o_ifid_flush=0, regardless of i_mode or i_step; counter decrements per cycle; at 1 -> HALTED.
REQ-017 HALTED: o_pipe_enable=0, o_halted=1; i_start, i_step ignored; exit only by reset.
REQ-018 o_cycle_count SHALL increment by 1 on every cycle with o_pipe_enable=1, wrap modulo 2^CNT_W, never reset except by i_rst.

Reset
REQ-019 i_rst=0 at a clock edge SHALL force IDLE, drain counter 0, step edge register 0, o_cycle_count 0; all outputs 0 in that cycle and until leaving IDLE.
REQ-020 Reset asserted mid-RUN, mid-STEP or mid-DRAIN SHALL abort immediately with no further enabled cycles.

Verification
REQ-021 Reset, i_start=1, i_mode=0, no hazards, 10 cycles -> RUN, o_pipe_enable=1, o_control_mux=1, o_cycle_count=10.
REQ-022 RUN, i_ex_MemRead=1, i_ex_rt=5, i_id_rs=5 one cycle -> o_pc_write=0, o_ifid_write=0, o_control_mux=0 that cycle; i_ex_rt=0 same stimulus -> no stall.
REQ-023 RUN, stall and i_ex_branch_taken=1 same cycle -> o_ifid_flush=1, o_pc_write=1, o_control_mux=0.
REQ-024 RUN, i_id_opcode=6'b111111 -> DRAIN 3 cycles (o_pc_write=0, o_pipe_enable=1), then o_halted=1, o_pipe_enable=0, o_cycle_count frozen; i_start ignored.
REQ-025 i_mode=1: i_step held high 5 cycles -> exactly one cycle o_pipe_enable=1, o_cycle_count=1; second 0->1 edge -> count=2.
REQ-026 i_rst=0 during DRAIN -> next cycle IDLE, o_running=0, o_halted=0, o_cycle_count=0.
